// File: rtl/mult_unit_pkg.sv
// Shared encodings for the iterative hi/lo multiplier: instruction ops,
// register-file write codes and controller states.
package mult_unit_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_MADD  = 2'd2,
        OP_MADDU = 2'd3
    } op_e;

    // Must stay aligned with the register file's hi/lo write decode.
    typedef enum logic [1:0] {
        MUL_NONE = 2'd0,
        MUL_LOAD = 2'd1,
        MUL_ACC  = 2'd2
    } mul_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // op[0] clear selects the signed variants (MULT, MADD).
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mult_datapath.sv
// Magnitude/sign capture, radix-2 shift-add accumulator and final sign
// restore for the hi/lo multiplier.
module mult_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             finish,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] write_data_1,
    output logic [WIDTH-1:0] write_data_2
);

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] result;
    logic               neg_flag;

    // Negating 0x80000000 yields 0x80000000, which read unsigned is 2^31.
    always_comb begin
        mag_a    = (is_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
        mag_b    = (is_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;
        addend   = mplier[0] ? mcand : '0;
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        acc_step = (2*WIDTH)'({sum, acc[WIDTH-1:0]} >> 1);
        result   = neg_flag ? -acc_step : acc_step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand        <= '0;
            mplier       <= '0;
            acc          <= '0;
            neg_flag     <= 1'b0;
            write_data_1 <= '0;
            write_data_2 <= '0;
        end else begin
            if (load) begin
                mcand    <= mag_a;
                mplier   <= mag_b;
                neg_flag <= is_signed & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                acc      <= '0;
            end else if (step) begin
                acc    <= acc_step;
                mplier <= mplier >> 1;
            end
            // Result registers only move on the last iteration, so they hold
            // the previous beat for the whole of the next operation.
            if (finish) begin
                {write_data_2, write_data_1} <= result;
            end
        end
    end

endmodule

// File: rtl/mult_unit.sv
// Iterative MULT/MULTU/MADD/MADDU unit: fixed-latency controller feeding a
// one-cycle hi/lo write beat to the register file.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// CALC  | one multiplier bit per edge, WIDTH edges
// DONE  | single result beat: done/write_enable high, mul valid
module mult_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             write_enable,
    output logic [1:0]       mul,
    output logic [WIDTH-1:0] write_data_1,
    output logic [WIDTH-1:0] write_data_2
);
    import mult_unit_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             acc_flag;
    logic             load;
    logic             step;
    logic             finish;

    assign load   = (state == IDLE) && start;
    assign step   = (state == CALC);
    assign finish = step && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                cnt      <= '0;
                acc_flag <= op[1];
            end else if (step) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        done         = 1'b0;
        write_enable = 1'b0;
        mul          = MUL_NONE;
        case (state)
            IDLE: begin
                if (start) state_nxt = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (finish) state_nxt = DONE;
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                write_enable = 1'b1;
                mul          = acc_flag ? MUL_ACC : MUL_LOAD;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .step         (step),
        .finish       (finish),
        .is_signed    (op_is_signed(op)),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .write_data_1 (write_data_1),
        .write_data_2 (write_data_2)
    );

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: vector table plus scoreboard of expected
// write beats, with hand sequences for ignore/reset/back-to-back cases.
module tb_mult_unit;
    import mult_unit_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, write_enable;
    logic [1:0]   mul;
    logic [W-1:0] write_data_1, write_data_2;

    int checks = 0;
    int failures = 0;
    int beats = 0;
    int exp_beats = 0;
    int cyc = 0;

    typedef struct {
        logic [1:0]   mul;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } beat_t;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   mul;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    beat_t sb[$];
    vec_t  vecs[9];

    mult_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .operand_a    (a),
        .operand_b    (b),
        .busy         (busy),
        .done         (done),
        .write_enable (write_enable),
        .mul          (mul),
        .write_data_1 (write_data_1),
        .write_data_2 (write_data_2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
        logic signed [63:0] sx, sy;
        if (o[0] == 1'b0) begin
            sx = {{W{x[W-1]}}, x};
            sy = {{W{y[W-1]}}, y};
            return 64'(sx * sy);
        end
        return {32'd0, x} * {32'd0, y};
    endfunction

    // Scoreboard monitor: every write beat must match the oldest expectation.
    always @(negedge clk) begin
        beat_t e;
        if (write_enable !== done) begin
            chk("we_eq_done", {63'd0, write_enable}, {63'd0, done});
        end
        if (write_enable === 1'b1) begin
            beats++;
            if (sb.size() == 0) begin
                chk("unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("beat_mul", {62'd0, mul}, {62'd0, e.mul});
                chk("beat_hilo", {write_data_2, write_data_1}, {e.hi, e.lo});
            end
        end else if (mul !== MUL_NONE) begin
            chk("mul_idle_zero", {62'd0, mul}, 64'd0);
        end
    end

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                            input bit push, input beat_t e);
        wait_idle();
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) begin
            sb.push_back(e);
            exp_beats++;
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        int nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) nb++;
        end while (!done && n < 60);
        chk({name, "_latency"}, 64'(n), 64'd33);
        chk({name, "_busy_cycles"}, 64'(nb), 64'd33);
        @(negedge clk);
        chk({name, "_busy_after"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        beat_t e;
        int t[3];
        int k, n, nb0;

        vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LOAD, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, MUL_LOAD, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{OP_MULT,  32'h80000000, 32'h80000000, MUL_LOAD, 32'h40000000, 32'h00000000};
        vecs[3] = '{OP_MADD,  32'hFFFFFFFF, 32'h00000001, MUL_ACC,  32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[4] = '{OP_MADDU, 32'h00000002, 32'h00000003, MUL_ACC,  32'h00000000, 32'h00000006};
        vecs[5] = '{OP_MULT,  32'h00000000, 32'hFFFFFFFF, MUL_LOAD, 32'h00000000, 32'h00000000};
        vecs[6] = '{OP_MULTU, 32'h80000000, 32'h00000002, MUL_LOAD, 32'h00000001, 32'h00000000};
        vecs[7] = '{OP_MULT,  32'h7FFFFFFF, 32'h80000000, MUL_LOAD, 32'hC0000000, 32'h80000000};
        vecs[8] = '{OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_ACC,  32'hFFFFFFFE, 32'h00000001};

        repeat (3) @(negedge clk);
        chk("reset_ctl", {60'd0, busy, done, write_enable, mul[0]}, 64'd0);
        chk("reset_data", {write_data_2, write_data_1}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ctl", {61'd0, busy, done, write_enable}, 64'd0);

        for (int i = 0; i < 9; i++) begin
            e = '{vecs[i].mul, vecs[i].hi, vecs[i].lo};
            start_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, e);
            wait_done($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            logic [63:0]  p;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            p  = model(ro, ra, rb);
            e  = '{(ro[1] ? MUL_ACC : MUL_LOAD), p[63:32], p[31:0]};
            start_op(ro, ra, rb, 1'b1, e);
            wait_done($sformatf("rand%0d", i));
        end

        // start during CALC with different operands must be ignored
        nb0 = beats;
        e = '{MUL_LOAD, 32'd0, 32'd63};
        start_op(OP_MULTU, 32'd7, 32'd9, 1'b1, e);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd5;
        b     = 32'hFFFFFFFB;
        repeat (8) @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("ignore_done_seen", {63'd0, done}, 64'd1);
        repeat (40) @(negedge clk);
        chk("ignore_one_beat", 64'(beats - nb0), 64'd1);

        // reset mid-CALC abandons the operation
        nb0 = beats;
        start_op(OP_MULTU, 32'h12345678, 32'd3, 1'b0, e);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_ctl", {60'd0, busy, done, write_enable, mul[0] | mul[1]}, 64'd0);
        chk("async_reset_data", {write_data_2, write_data_1}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        chk("no_beat_after_reset", 64'(beats - nb0), 64'd0);
        e = '{MUL_LOAD, 32'd0, 32'd63};
        start_op(OP_MULTU, 32'd7, 32'd9, 1'b1, e);
        wait_done("post_reset");

        // back-to-back with start held high
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{MUL_LOAD, 32'd0, 32'd12});
            exp_beats++;
        end
        wait_idle();
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd3;
        b     = 32'd4;
        k = 0;
        n = 0;
        while (k < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (done) begin
                t[k] = cyc;
                k++;
                if (k == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("b2b_count", 64'(k), 64'd3);
        chk("b2b_gap0", 64'(t[1] - t[0]), 64'd34);
        chk("b2b_gap1", 64'(t[2] - t[1]), 64'd34);
        repeat (40) @(negedge clk);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("beat_total", 64'(beats), 64'(exp_beats));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative radix-2 shift-add multiplier for MULT, MULTU, MADD and MADDU.
- Sits directly upstream of the register file's hi/lo path.
- Consumes two 32-bit GPR operands from the decode/read stage.
- Produces a one-cycle write beat: write_enable, mul code, write_data_1 (lo), write_data_2 (hi). The register file either loads {hi,lo} or accumulates into it.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH.
CNT_W, 6, width of the iteration counter; must hold WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a multiply; sampled only in IDLE
op  input  2  0=MULT (signed), 1=MULTU, 2=MADD (signed), 3=MADDU
operand_a  input  WIDTH  rs value
operand_b  input  WIDTH  rt value
busy  output  1  high in CALC and DONE
done  output  1  one-cycle pulse; result beat valid
write_enable  output  1  equals done
mul  output  2  1 = load {hi,lo}; 2 = accumulate; 0 when not done
write_data_1  output  WIDTH  product low word (lo)
write_data_2  output  WIDTH  product high word (hi)

Behaviour:
- Reset: clk and rst_n are the only clock and reset. rst_n low forces the following immediately, without a clock:
  - state=IDLE
  - busy=0, done=0, write_enable=0, mul=0
  - write_data_1=0, write_data_2=0
  - counter, multiplicand, accumulator and sign flag cleared
- Reset mid-operation: the operation is abandoned and no write beat is ever issued for it.
- FSM has three states: IDLE, CALC, DONE.
- IDLE:
  - start=1 at edge E0 latches |operand_a| and |operand_b| (magnitudes only for signed ops), the sign flag (a[31]^b[31] for signed ops, else 0), op[1] (the accumulate flag), and counter=0.
  - The accumulator is cleared and the state moves to CALC.
  - start=0 keeps the FSM in IDLE.
- CALC: one edge per multiplier bit, LSB first.
  - If the current multiplier bit is 1, add the multiplicand into the upper half of the 2*WIDTH accumulator, keeping the carry.
  - Shift the accumulator right by 1.
  - counter increments.
  - After WIDTH edges (E1..E32) the state moves to DONE.
- Fixed latency: zero or one operands do not short-circuit.
- DONE (cycle after E32, one cycle only):
  - done=1 and write_enable=1.
  - mul=2 if the accumulate flag is set, else mul=1.
  - {write_data_2, write_data_1} = sign flag ? two's-complement negation of the accumulator : accumulator.
  - Edge E33 returns the state to IDLE.
- Data outputs hold their last value outside DONE; consumers qualify them with write_enable.
- Latency: done is high in the 33rd cycle after the edge that accepted start.
- Next start is accepted no earlier than edge E33+1.
- start while busy=1 is ignored and not queued. Upstream must stall on busy.
- Operands and op are sampled only at E0; later changes have no effect.
- -2^31 magnitude: 0x80000000 as an unsigned magnitude is 2^31. The product is formed in 2*WIDTH unsigned arithmetic, so no overflow.
- Accumulation arithmetic, including the 64-bit carry from lo into hi, happens in the register file. This block supplies only the signed or unsigned product.
- MADD of negative products relies on the 64-bit two's-complement product, sign-correct for the 64-bit add.

Decomposition:
- Shared package:
  - op encodings OP_MULT/OP_MULTU/OP_MADD/OP_MADDU
  - mul codes MUL_NONE=0, MUL_LOAD=1, MUL_ACC=2 (must match the register-file encoding)
  - state encoding IDLE/CALC/DONE
- One natural sub-module: mult_datapath (magnitude/sign capture, shift-add accumulator, final negation). FSM and counter stay in mult_unit.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF, start at E0 -> done at cycle 33, mul=1, hi=0xFFFFFFFE, lo=0x00000001. busy high for exactly 33 cycles.
- MULT -3*5 -> mul=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000.
- MADD -1*1 then MADDU 2*3 -> first beat mul=2, hi=0xFFFFFFFF, lo=0xFFFFFFFF. Second beat mul=2, hi=0, lo=6. With the register file attached and {hi,lo} preloaded to 1, the final {hi,lo}=6.
- start re-asserted with different operands during CALC -> ignored. The result equals the first request's product, and exactly one write beat occurs.
- rst_n pulsed low at cycle 10 of CALC -> outputs zero immediately, no done pulse ever. A new MULTU 7*9 after release -> lo=63, hi=0 at 33 cycles.
- Back-to-back: start held high continuously -> done pulses spaced 34 cycles apart, write_enable never high outside DONE, mul=0 between beats.
